// File: rtl/paraller_filter.sv
// 3x3 Gaussian filter over a preloaded padded image held in the mem instance.
// Produces one filtered pixel per enabled cycle, scanning row-major.

module paraller_filter_mem #(
  parameter int PAD_N = 66,
  parameter int DW    = 8,
  parameter int AW    = 7
) (
  input  logic [AW-1:0]   row,
  input  logic [AW-1:0]   col,
  output logic [9*DW-1:0] win
);
  // Contents are loaded from outside by hierarchical assignment; no write port.
  logic [DW-1:0] mem_read [0:PAD_N-1][0:PAD_N-1];

  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned j = 0; j < 3; j++) begin
        win[(i*3+j)*DW +: DW] = mem_read[row + AW'(i)][col + AW'(j)];
      end
    end
  end
endmodule

module paraller_filter #(
  parameter int IMG_N = 64,
  parameter int PAD_N = 66,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          rd,
  output logic [DW-1:0] cl_pixel
);
  localparam int CW = $clog2(IMG_N);
  localparam int AW = $clog2(PAD_N);
  localparam int SW = DW + 4;
  localparam logic [CW-1:0] LAST = CW'(IMG_N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [CW-1:0]  r;
  logic [CW-1:0]  c;
  logic [9*DW-1:0] win;
  logic [DW-1:0]  p [0:8];
  logic [SW-1:0]  sum;

  paraller_filter_mem #(
    .PAD_N(PAD_N),
    .DW   (DW),
    .AW   (AW)
  ) mem (
    .row(AW'(r)),
    .col(AW'(c)),
    .win(win)
  );

  always_comb begin
    for (int unsigned k = 0; k < 9; k++) begin
      p[k] = win[k*DW +: DW];
    end
    // Weights 1 2 1 / 2 4 2 / 1 2 1 as shifts; total weight 16.
    sum = SW'(p[0]) + (SW'(p[1]) << 1) + SW'(p[2])
        + (SW'(p[3]) << 1) + (SW'(p[4]) << 2) + (SW'(p[5]) << 1)
        + SW'(p[6]) + (SW'(p[7]) << 1) + SW'(p[8]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      r        <= '0;
      c        <= '0;
      rd       <= 1'b0;
      cl_pixel <= '0;
    end else begin
      rd <= 1'b0;
      case (state)
        IDLE: if (en) state <= RUN;
        RUN: begin
          if (en) begin
            rd       <= 1'b1;
            cl_pixel <= sum[SW-1:4];
            if (c == LAST) begin
              c <= '0;
              if (r == LAST) state <= DONE;
              else           r <= r + CW'(1);
            end else begin
              c <= c + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_paraller_filter.sv
// Scoreboard bench for paraller_filter: directed images with hand-derived outputs,
// enable gap, mid-run reset and post-run quiescence.

module tb_paraller_filter;
  localparam int IMG_N = 64;
  localparam int PAD_N = 66;
  localparam int DW    = 8;
  localparam int NPIX  = IMG_N * IMG_N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic rd;
  logic [DW-1:0] cl_pixel;

  paraller_filter #(
    .IMG_N(IMG_N),
    .PAD_N(PAD_N),
    .DW   (DW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .rd      (rd),
    .cl_pixel(cl_pixel)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic [DW-1:0] val;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rd === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rd", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("pix_%0d_%0d", e.idx / IMG_N, e.idx % IMG_N), 32'(cl_pixel), 32'(e.val));
      end
      pulse_cnt++;
    end
  end

  // kind: 0 all 0x80, 1 single 0xFF at [1][1], 2 all 0xFF, 3 ramp by column
  task automatic load(input int kind);
    logic [DW-1:0] v;
    for (int i = 0; i < PAD_N; i++) begin
      for (int j = 0; j < PAD_N; j++) begin
        case (kind)
          0: v = 8'h80;
          1: v = (i == 1 && j == 1) ? 8'hFF : 8'h00;
          2: v = 8'hFF;
          default: v = DW'(j);
        endcase
        dut.mem.mem_read[i][j] = v;
      end
    end
  endtask

  task automatic push_exp(input int kind);
    exp_t e;
    int r, c;
    for (int idx = 0; idx < NPIX; idx++) begin
      r = idx / IMG_N;
      c = idx % IMG_N;
      e.idx = idx;
      case (kind)
        0: e.val = 8'h80;
        1: begin
          if (r == 0 && c == 0)                              e.val = 8'h3F;
          else if ((r == 0 && c == 1) || (r == 1 && c == 0)) e.val = 8'h1F;
          else if (r == 1 && c == 1)                         e.val = 8'h0F;
          else                                               e.val = 8'h00;
        end
        2: e.val = 8'hFF;
        default: e.val = DW'(c + 1);
      endcase
      sb.push_back(e);
    end
  endtask

  task automatic start_run(input int kind);
    rst_n = 1'b0;
    en    = 1'b0;
    #3;
    sb.delete();
    pulse_cnt = 0;
    load(kind);
    push_exp(kind);
    #1;
    check("reset_rd", 32'(rd), 32'd0);
    check("reset_pixel", 32'(cl_pixel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("first_rd_latency", 32'(rd), 32'd1);
  endtask

  task automatic wait_pulses(input int target);
    int n = 0;
    while (pulse_cnt < target && n < NPIX + 200) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  task automatic finish_run(input logic [DW-1:0] last_val);
    wait_pulses(NPIX);
    check("pulse_count", 32'(pulse_cnt), 32'(NPIX));
    check("queue_empty", 32'(sb.size()), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("done_rd", 32'(rd), 32'd0);
      check("done_hold", 32'(cl_pixel), 32'(last_val));
    end
    check("done_pulse_count", 32'(pulse_cnt), 32'(NPIX));
  endtask

  initial begin
    start_run(0);
    finish_run(8'h80);

    start_run(1);
    finish_run(8'h00);

    start_run(2);
    finish_run(8'hFF);

    // Ramp with a 10-cycle enable gap after output 99 (pixel (1,35) -> 0x24)
    start_run(3);
    wait_pulses(100);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("gap_rd", 32'(rd), 32'd0);
      check("gap_hold", 32'(cl_pixel), 32'h24);
    end
    check("gap_count", 32'(pulse_cnt), 32'd100);
    @(negedge clk);
    en = 1'b1;
    finish_run(8'h40);

    // Impulse image, aborted by reset after output 1999, then a full rerun
    start_run(1);
    wait_pulses(2000);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_rd", 32'(rd), 32'd0);
    check("abort_pixel", 32'(cl_pixel), 32'd0);
    check("mem_kept", 32'(dut.mem.mem_read[1][1]), 32'hFF);
    start_run(1);
    finish_run(8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/paraller_filter.md
PARALLER_FILTER -- requirements
Module: paraller_filter

Interface
REQ-001 SHALL have parameter IMG_N, default 64, meaning output image width and height in pixels.
REQ-002 SHALL have parameter PAD_N, default 66 (IMG_N+2), meaning stored padded image width and height.
REQ-003 SHALL have parameter DW, default 8, meaning pixel width in bits.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port en, input, 1 bit: run enable; while low, processing pauses.
REQ-008 SHALL have port rd, output, 1 bit: result-valid strobe, high for one cycle per filtered pixel.
REQ-009 SHALL have port cl_pixel, output, DW bits: filtered pixel value.
REQ-010 SHALL order ports exactly as (clk, rst_n, en, rd, cl_pixel), so positional instantiation works.
REQ-011 SHALL contain a storage submodule instance named mem holding reg array mem_read[0:PAD_N-1][0:PAD_N-1] of DW bits.
- The array SHALL be preloaded externally by hierarchical assignment.
- It SHALL have no write port and SHALL never be modified by the design.

Function
REQ-012 SHALL compute, for output pixel (r,c), r,c in 0..IMG_N-1, a 3x3 Gaussian over window mem_read[r..r+2][c..c+2].
- Weights: [1 2 1; 2 4 2; 1 2 1].
REQ-013 SHALL read all nine window pixels in parallel in the same cycle and sum them in a 12-bit unsigned accumulator.
REQ-014 SHALL set cl_pixel = sum >> 4 (truncating); the maximum result is 4080>>4 = 255, so no saturation is needed.
REQ-015 SHALL scan output pixels row-major: c increments 0..IMG_N-1, then wraps to 0 and r increments.
REQ-016 SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-017 Transitions SHALL be:
- IDLE->RUN when en=1.
- RUN->DONE after pixel (IMG_N-1, IMG_N-1) is processed.
- DONE is terminal until reset.
REQ-018 In RUN, in each cycle with en=1, the design SHALL process the current (r,c) and advance the counters.
REQ-019 cl_pixel and rd SHALL be registered, with latency of exactly 1 cycle.
- The result for the window processed in cycle k appears with rd=1 after clock edge k+1.
REQ-020 When en=0 in RUN:
- Counters SHALL hold.
- rd SHALL be 0 in the following cycle.
- cl_pixel SHALL hold its last value.
REQ-021 On resuming en=1, processing SHALL continue at the held (r,c), with no pixel skipped or duplicated.
REQ-022 Exactly IMG_N*IMG_N rd pulses SHALL occur per run (4096 by default).
- After the last pulse, rd SHALL stay 0 and cl_pixel SHALL hold the final value.
REQ-023 In IDLE and DONE, rd SHALL be 0.
REQ-024 Indexing SHALL never exceed PAD_N-1 in either dimension.

Reset
REQ-025 While rst_n=0, regardless of clk:
- state SHALL be IDLE, r=c=0, rd=0, cl_pixel=0.
REQ-026 Reset asserted mid-run SHALL abort immediately.
- After release, the next run SHALL restart at (0,0).
- mem contents SHALL be unaffected by reset.
REQ-027 After rst_n deassertion with en=1, the first rd pulse SHALL occur within 2 clock edges and carry pixel (0,0).

Verification
REQ-028 All mem bytes 0x80, en=1 after reset -> 4096 rd pulses, each cl_pixel=0x80, then rd stays 0.
REQ-029 mem[1][1]=0xFF, all others 0 -> first outputs:
- (0,0)=0x3F, (0,1)=0x1F, (0,2)=0x00.
- (1,0)=0x1F, (1,1)=0x0F.
REQ-030 All mem bytes 0xFF -> every cl_pixel=0xFF (no overflow).
REQ-031 Ramp mem[i][j]=j -> output (r,c) = c+1 for all rows.
- Example: (5,10)=0x0B.
REQ-032 en dropped for 10 cycles at output 100 -> rd=0 during the gap.
- The next pulse SHALL be output 100 with the correct value; 4096 pulses total.
REQ-033 rst_n pulsed low at output 2000 -> rd=0 and cl_pixel=0 immediately.
- After release, outputs restart at (0,0) with the REQ-029/REQ-031 expected values.
